// File: rtl/serial_addsub_if.sv
// serial_addsub_if: operand/result bundle for the bit-serial adder.
// Master drives the request, slave returns status and result.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start,
        output sub,
        output a,
        output b,
        input  busy,
        input  done,
        input  sum,
        input  cout,
        input  ovf
    );

    modport slave (
        input  start,
        input  sub,
        input  a,
        input  b,
        output busy,
        output done,
        output sum,
        output cout,
        output ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement add/subtract.
// One full-adder cell and a carry flop, one bit per clock, LSB first.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    serial_addsub_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opa_d;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] opb_d;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             carry_q;
    logic             carry_d;
    logic             cmsb_q;
    logic             cmsb_d;
    logic             cout_q;
    logic             cout_d;
    logic             ovf_q;
    logic             ovf_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_shift;

    // The single full-adder cell working on the current LSBs.
    assign fa_s = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign fa_c = (opa_q[0] & opb_q[0])
                | (opa_q[0] & carry_q)
                | (opb_q[0] & carry_q);

    // Result bits enter at the MSB so the LSB lands at bit 0 last.
    assign res_shift = {fa_s, res_q[WIDTH-1:1]};

    // Next-state and datapath update; defaults hold every register.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Subtract is a + ~b + 1: invert b, carry-in of 1.
                    opa_d   = bus.a;
                    opb_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    res_d   = '0;
                    cmsb_d  = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                opa_d   = {1'b0, opa_q[WIDTH-1:1]};
                opb_d   = {1'b0, opb_q[WIDTH-1:1]};
                res_d   = res_shift;
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                // Carry into the MSB, needed for signed overflow.
                if (cnt_q == PENULT) begin
                    cmsb_d = fa_c;
                end
                if (cnt_q == LAST) begin
                    sum_d   = res_shift;
                    cout_d  = fa_c;
                    ovf_d   = cmsb_q ^ fa_c;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial two's-complement adder/subtractor built around a single full-adder cell and a carry flip-flop.
- Accepts a parallel operand pair on a start handshake and processes one bit per clock, LSB first.
- Returns a parallel result with carry-out and signed overflow, plus a one-cycle done pulse.
- Sits beside the combinational adder blocks as the area-minimal sequential datapath of the arithmetic library.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only when busy=0
sub  in  1  operation select sampled with start: 0 = a+b, 1 = a-b
a  in  WIDTH  operand A, sampled with start
b  in  WIDTH  operand B, sampled with start
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse, result valid
sum  out  WIDTH  result, held between operations
cout  out  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned)
ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. Reset dominates all other inputs on the same edge.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. Internal shift registers, bit counter and carry are also cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at edge k:
  - latch opA=a and opB = sub ? ~b : b
  - carry=sub, count=0, result shift register cleared
  - go RUN
  - busy=1 from edge k
- IDLE with start=0: stay IDLE.
- DONE with start=0: go IDLE.
- RUN, each edge:
  - s = opA[0]^opB[0]^carry
  - c = majority(opA[0], opB[0], carry)
  - shift opA and opB right by 1
  - shift s into the result register at the MSB end (result shifts right)
  - carry=c, count++
  - On the bit WIDTH-2 step, also record carry-into-MSB (the c produced there) for ovf.
- RUN, last bit (count=WIDTH-1), at edge k+WIDTH:
  - sum = final result register value, cout = c, ovf = c_into_msb ^ c
  - done=1, busy=0, go DONE
- Latency: start sampled at edge k → done high for exactly the cycle between edges k+WIDTH and k+WIDTH+1. Throughput is one operation per WIDTH+1 cycles, with back-to-back start accepted in DONE.
- start while busy=1 is ignored. No queuing, no effect on the in-flight operation.
- Input isolation: a, b and sub changes while busy=1 do not affect the result; only values sampled at the start edge are used.
- Output hold: sum/cout/ovf change only on the done edge or reset. They hold their value through IDLE, DONE and the next RUN.
- done is never high while busy is high. done is high for exactly 1 cycle per accepted start.
- Reset mid-operation: abort immediately on the next edge to reset values, with no done pulse. The next start after reset behaves as from power-up.
- Arithmetic is modulo 2^WIDTH. Subtract is a + ~b + 1. Special case a-b with b=0: cout=1, ovf=0.

Test Plan (WIDTH=8):
1. Reset, then start add a=0x00 b=0x00 → busy 8 cycles; done pulse 8 edges after the start edge; sum=0x00, cout=0, ovf=0. Outputs read 0 during reset.
2. Add a=0xFF b=0x01 → sum=0x00, cout=1, ovf=0. Then back-to-back start in DONE cycle with add a=0x7F b=0x01 → sum=0x80, cout=0, ovf=1, done again exactly 8 edges after second start.
3. Sub a=0x05 b=0x07 → sum=0xFE, cout=0, ovf=0. Sub a=0x80 b=0x01 → sum=0x7F, cout=1, ovf=1. Sub a=0x33 b=0x00 → sum=0x33, cout=1, ovf=0.
4. Start add a=0x10 b=0x20, then hold start=1 and toggle a=0xFF b=0xFF sub=1 every cycle while busy → single done pulse, sum=0x30, cout=0, ovf=0. No second operation begins until busy=0.
5. Start add a=0x55 b=0x0A, assert reset for one edge at the 4th RUN cycle → busy=0, done=0, sum/cout/ovf=0, no done pulse afterwards. Next add a=0x01 b=0x02 → sum=0x03.
6. Random regression of 1000 ops with random sub against a reference model, including idle gaps and back-to-back starts → sum/cout/ovf match every done pulse; done count equals accepted start count.
